fetch_sequencer: RTL
====================

Name: fetch_sequencer

Overview:
Multi-cycle controller that sequences instruction fetch for the core. It owns the program counter, drives the instruction memory address, and captures the returned word after a fixed read latency. It hands the instruction to execute over a valid/ready handshake, waits for completion, then selects the next PC (sequential or conditional branch).

Parameters:
ADDR_W, 8, PC / memory address width
INSTR_W, 16, instruction width
DATA_W, 16, ALU result width
MEM_LAT, 1, instruction memory read latency in cycles (legal 1..4)
RESET_PC, 0, PC value loaded on reset

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-low reset (0 = reset)
run  in  1  1 = keep fetching; 0 = stop at next instruction boundary
mem_addr  out  ADDR_W  instruction memory address (= current PC)
mem_data  in  INSTR_W  instruction memory read data, valid MEM_LAT cycles after address
instr_out  out  INSTR_W  captured instruction to execute
instr_valid  out  1  instr_out valid for execute
instr_ready  in  1  execute accepts instr_out
exec_done  in  1  one-cycle pulse: execute finished the issued instruction
alu_result  in  DATA_W  result accompanying exec_done
pc_out  out  ADDR_W  current PC
branch_taken  out  1  one-cycle pulse when a branch redirects the PC
busy  out  1  FSM not in IDLE
retired  out  16  count of completed instructions, saturating at 16'hFFFF

Behaviour:
- Reset (reset==0 at posedge): state=IDLE; pc=RESET_PC; instr_out=0; last_alu=0; retired=0; instr_valid=0; branch_taken=0; busy=0; latency counter=0. Reset mid-operation abandons the instruction in flight; no retire and no PC update.
- mem_addr = pc_out = pc at all times.
- States: IDLE, REQ, ISSUE, EXEC, NEXT.
- IDLE: run==1 -> REQ; otherwise hold.
- REQ: counter counts 0..MEM_LAT-1. At count MEM_LAT-1, capture mem_data into instr_out, clear counter, -> ISSUE. With MEM_LAT=1 this takes 1 cycle in REQ.
- ISSUE: instr_valid=1, instr_out stable. On instr_valid&&instr_ready -> EXEC. instr_valid must not drop before acceptance.
- EXEC: wait for exec_done. exec_done is ignored in every other state. On exec_done -> NEXT. If the format (instr_out[1:0]) != 2'b10, last_alu <= alu_result. Branches never update last_alu.
- NEXT (1 cycle):
  - If instr_out[1:0]==2'b10, cond=instr_out[3:2], tgt=instr_out[11:4]:
    - cond 00: taken iff last_alu==0
    - cond 01: taken iff last_alu==1
    - cond 10: taken iff last_alu==2
    - cond 11: never taken
  - pc <= taken ? tgt : pc+1. pc+1 wraps modulo 2^ADDR_W (8'hFF -> 8'h00).
  - branch_taken=1 during NEXT iff taken.
  - retired++ unless already saturated.
  - Next state: run ? REQ : IDLE.
- run is sampled only in IDLE and NEXT. Deasserting run mid-instruction completes that instruction.
- Throughput at MEM_LAT=1 with immediate ready/done: one instruction per 4 cycles (REQ, ISSUE, EXEC, NEXT).

Decomposition:
- Shared package fetch_pkg: state enum (fetch_state_t), FMT_BRANCH=2'b10, branch condition codes COND_EQ0=2'b00, COND_EQ1=2'b01, COND_EQ2=2'b10.
- Sub-module next_pc_sel: combinational next-PC and taken computation from instr_out, pc and last_alu. This is the only sub-module; the FSM, counters and registers stay in fetch_sequencer.

Test Plan:
- Reset then run=1, mem holds non-branch words, ready=1, done returned 1 cycle after accept -> mem_addr steps 0,1,2,… every 4 cycles; retired increments once per instruction; branch_taken stays 0.
- last_alu=0 (prior ALU op result 0), then branch 16'h0502 (tgt 8'h50, cond 00) -> pc=8'h50 after NEXT, branch_taken pulses 1 cycle, last_alu unchanged.
- last_alu=3, then branch with cond 10 to tgt 8'h20 at pc 8'h07 -> not taken, pc=8'h08. Then cond 11 with last_alu=2 -> not taken.
- MEM_LAT=3, instr_ready held low 5 cycles after instr_valid rises -> 3 cycles in REQ; instr_valid and instr_out stable for 5 cycles; exec_done pulsed during ISSUE is ignored.
- Non-branch at pc 8'hFF -> pc wraps to 8'h00. Drop run during EXEC -> instruction retires, FSM enters IDLE, busy=0.
- Assert reset (0) during EXEC -> next cycle state IDLE, pc=RESET_PC, retired=0, instr_valid=0.

Source files
------------

// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared types and constants for the instruction fetch sequencer.
//   fetch_state_t : fetch FSM states
//   FMT_BRANCH    : instruction format code (instr[1:0]) of a conditional branch
//   COND_EQx      : branch condition codes (instr[3:2]), taken when last ALU
//                   result equals x; the remaining code is never taken
//   CNT_W         : width of the memory-latency counter (MEM_LAT up to 4)
// -----------------------------------------------------------------------------
package fetch_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    ISSUE,
    EXEC,
    NEXT
  } fetch_state_t;

  localparam logic [1:0] FMT_BRANCH = 2'b10;

  localparam logic [1:0] COND_EQ0 = 2'b00;
  localparam logic [1:0] COND_EQ1 = 2'b01;
  localparam logic [1:0] COND_EQ2 = 2'b10;

  localparam int unsigned CNT_W = 2;

  function automatic logic is_branch(input logic [1:0] fmt);
    return fmt == FMT_BRANCH;
  endfunction

endpackage

// File: rtl/next_pc_sel.sv
// -----------------------------------------------------------------------------
// next_pc_sel
// Combinational next-PC selection for the fetch sequencer.
//   instr_i    : low bits of the current instruction (format, cond, target)
//   pc_i       : current program counter
//   last_alu_i : result of the most recent non-branch instruction
//   next_pc_o  : branch target if taken, otherwise pc_i + 1 (wrapping)
//   taken_o    : the instruction is a branch whose condition holds
// -----------------------------------------------------------------------------
module next_pc_sel
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 16
) (
  input  logic [ADDR_W+3:0] instr_i,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic [DATA_W-1:0] last_alu_i,
  output logic [ADDR_W-1:0] next_pc_o,
  output logic              taken_o
);

  logic [1:0]        cond;
  logic [ADDR_W-1:0] tgt;

  assign cond = instr_i[3:2];
  assign tgt  = instr_i[ADDR_W+3:4];

  always_comb begin
    taken_o = 1'b0;
    if (is_branch(instr_i[1:0])) begin
      case (cond)
        COND_EQ0: taken_o = (last_alu_i == DATA_W'(0));
        COND_EQ1: taken_o = (last_alu_i == DATA_W'(1));
        COND_EQ2: taken_o = (last_alu_i == DATA_W'(2));
        default:  taken_o = 1'b0;
      endcase
    end
    next_pc_o = taken_o ? tgt : (pc_i + ADDR_W'(1));
  end

endmodule

// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
// Multi-cycle instruction fetch controller. Owns the PC, reads instruction
// memory with a fixed latency, hands the word to execute over valid/ready,
// waits for the execute-done pulse, then selects the next PC.
//   clk          : system clock, all state on rising edge
//   reset        : synchronous active-low reset
//   run          : keep fetching (sampled only in IDLE and NEXT)
//   mem_addr     : instruction memory address (= PC)
//   mem_data     : instruction memory read data, MEM_LAT cycles after address
//   instr_out    : captured instruction
//   instr_valid  : instr_out offered to execute
//   instr_ready  : execute accepts instr_out
//   exec_done    : one-cycle pulse, execute finished (honoured in EXEC only)
//   alu_result   : result accompanying exec_done
//   pc_out       : current PC
//   branch_taken : high during NEXT when a branch redirects the PC
//   busy         : FSM not in IDLE
//   retired      : completed instruction count, saturating
// -----------------------------------------------------------------------------
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int unsigned           ADDR_W   = 8,
  parameter int unsigned           INSTR_W  = 16,
  parameter int unsigned           DATA_W   = 16,
  parameter int unsigned           MEM_LAT  = 1,
  parameter logic [ADDR_W-1:0]     RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic [INSTR_W-1:0] mem_data,
  output logic [INSTR_W-1:0] instr_out,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic               exec_done,
  input  logic [DATA_W-1:0]  alu_result,
  output logic [ADDR_W-1:0]  pc_out,
  output logic               branch_taken,
  output logic               busy,
  output logic [15:0]        retired
);

  localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(MEM_LAT - 1);

  fetch_state_t       state_q,    state_d;
  logic [ADDR_W-1:0]  pc_q,       pc_d;
  logic [INSTR_W-1:0] instr_q,    instr_d;
  logic [DATA_W-1:0]  last_alu_q, last_alu_d;
  logic [15:0]        retired_q,  retired_d;
  logic [CNT_W-1:0]   cnt_q,      cnt_d;

  logic [ADDR_W-1:0]  next_pc;
  logic               taken;

  next_pc_sel #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_next_pc_sel (
    .instr_i    (instr_q[ADDR_W+3:0]),
    .pc_i       (pc_q),
    .last_alu_i (last_alu_q),
    .next_pc_o  (next_pc),
    .taken_o    (taken)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      instr_q    <= '0;
      last_alu_q <= '0;
      retired_q  <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      last_alu_q <= last_alu_d;
      retired_q  <= retired_d;
      cnt_q      <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    last_alu_d = last_alu_q;
    retired_d  = retired_q;
    cnt_d      = cnt_q;

    case (state_q)
      IDLE: begin
        if (run) state_d = REQ;
      end

      // PC is held on mem_addr for the whole stay; capture on the last count.
      REQ: begin
        if (cnt_q == LAT_LAST) begin
          instr_d = mem_data;
          cnt_d   = '0;
          state_d = ISSUE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ISSUE: begin
        if (instr_ready) state_d = EXEC;
      end

      EXEC: begin
        if (exec_done) begin
          state_d = NEXT;
          // Branches leave the condition source untouched.
          if (!is_branch(instr_q[1:0])) last_alu_d = alu_result;
        end
      end

      NEXT: begin
        pc_d = next_pc;
        if (retired_q != 16'hFFFF) retired_d = retired_q + 16'd1;
        state_d = run ? REQ : IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign mem_addr     = pc_q;
  assign pc_out       = pc_q;
  assign instr_out    = instr_q;
  assign instr_valid  = (state_q == ISSUE);
  assign busy         = (state_q != IDLE);
  assign branch_taken = (state_q == NEXT) && taken;
  assign retired      = retired_q;

endmodule
